mod_uart_tx: RTL and testbench
==============================

# mod_uart_tx

- UART transmitter: serialises one byte per request into an 8-N-1 frame on `tx`, or 8-E-1 when parity is compiled in.
- Pairs with the receive path: same `SAMPLE_RATE` meaning, same sample-clock derivation, same 16x oversample bit period, so a receiver and transmitter with equal parameters interoperate.
- Contains its own baud divider, frame FSM and byte shift register.

## Interface

Parameters:
- `SAMPLE_RATE`, default 4: divider terminal count. The divider counts 0..`SAMPLE_RATE` and toggles `baud_rate_sample_clk` at the terminal count.
- `OVERSAMPLE`, default 16: sample-clock periods per bit.

Derived: BIT_CLKS = 2*(SAMPLE_RATE+1)*OVERSAMPLE, which is 160 at defaults.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `tx_start`  in  1: send request, level-sampled.
- `tx_data`  in  8: byte to send, sampled on acceptance.
- `tx`  out  1: serial line; idles high; registered.
- `tx_busy`  out  1: high while a frame is in progress.
- `tx_done`  out  1: one-cycle pulse at the end of the stop bit.
- `baud_rate_sample_clk`  out  1: divided sample clock, for debug and for sharing with the receiver.

## Operation

- **Reset values** (applied immediately while `reset`=0): `tx`=1, `tx_busy`=0, `tx_done`=0, `baud_rate_sample_clk`=0, FSM=IDLE, divider and counters = 0.
- **Acceptance:** in IDLE, `tx_start`=1 at a rising edge accepts the request.
  - `tx_data` is latched into the shift register.
  - The divider, tick counter and bit counter are cleared.
  - FSM goes to START.
- **Ignored requests:** `tx_start` is ignored while `tx_busy`=1. Changes to `tx_data` after acceptance have no effect.
- **States and transitions:**
  - IDLE: `tx`=1. Goes to START on acceptance.
  - START: `tx`=0 for BIT_CLKS cycles, then DATA.
  - DATA: `tx` = shift register bit 0. Shift right each BIT_CLKS; 8 bits are sent LSB first. After bit 7, go to PARITY (if compiled) or STOP.
  - PARITY: `tx` = XOR of the latched byte (even parity) for BIT_CLKS cycles, then STOP.
  - STOP: `tx`=1 for BIT_CLKS cycles, then IDLE with a `tx_done` pulse.
- **Bit timing:**
  - A one-cycle enable `sample_tick` fires each full sample-clock period, i.e. every 2*(SAMPLE_RATE+1) clocks.
  - A 4-bit tick counter advances the bit after `OVERSAMPLE` ticks.
  - A 3-bit bit counter tracks data bits and wraps 7→0 on DATA exit.
- **Divider:** free-runs in IDLE, so `baud_rate_sample_clk` is continuous except for the clear at acceptance.
- **`tx_busy`:** is 1 in every state except IDLE.

## Timing

- Request accepted at edge N: `tx` falls and `tx_busy` rises after edge N (visible in cycle N+1).
- Every bit, including start and stop, is exactly BIT_CLKS cycles with no jitter.
- Frame length is 10*BIT_CLKS (1600 at defaults), or 11*BIT_CLKS with parity. `tx_busy` is high for exactly that many cycles.
- `tx_done`: high for one cycle, in the first IDLE cycle after the stop bit. `tx_busy` is 0 in that same cycle.
- Back-to-back: `tx_start`=1 in the `tx_done` cycle is accepted. The next start bit follows immediately with zero idle cycles.
- `tx_start` held high continuously sends `tx_data` repeatedly, back-to-back.
- Reset asserted mid-frame: `tx` goes to 1 asynchronously and the frame is abandoned. No `tx_done` is produced. After release, the first accepted `tx_start` sends a fresh, complete frame.
- Reset release has no minimum idle requirement before the first request.

## Configuration

- Macro: `UART_TX_PARITY_EN`.
- **Defined:** the PARITY state is compiled in. Frame is start, 8 data bits, even-parity bit, stop (11 bits).
- **Undefined:** the PARITY state and parity logic are absent. DATA goes directly to STOP; frame is 10 bits.
- Ports and parameters are identical in both builds.

## Test plan

- **Reset values:** hold `reset`=0 → `tx`=1, `tx_busy`=0, `tx_done`=0, `baud_rate_sample_clk`=0.
- **Single frame:** send 8'hA5 at defaults, no parity → on `tx`, measured in 160-clk slots: 0, then 1,0,1,0,0,1,0,1, then 1. `tx_busy` high for 1600 cycles. One `tx_done` pulse at cycle 1601.
- **Parity:** with `UART_TX_PARITY_EN`:
  - 8'h07 → parity bit 1, frame 1760 cycles.
  - 8'h03 → parity bit 0.
- **Back-to-back:** hold `tx_start` with 8'h55 then 8'h00 → second start bit begins the cycle after `tx_done`, with no high gap.
- **Busy rejection:** pulse `tx_start` with 8'hFF mid-frame of 8'h12 → only 8'h12 is transmitted; a single `tx_done` pulse.
- **Reset mid-frame:** assert reset during data bit 3 → `tx`=1 within the same cycle, no `tx_done`. After release, 8'h3C is sent correctly.
- **Loopback:** connect `tx` to the receiver with `SAMPLE_RATE`=4 → `rx_data` equals the sent byte for 0x00, 0xFF, 0x5A.

Source files
------------

// File: rtl/mod_uart_tx.sv
// UART transmitter: 8-N-1 frames (8-E-1 when UART_TX_PARITY_EN is defined),
// with its own 16x-oversample baud divider, frame FSM and byte shift register.
module mod_uart_tx #(
  parameter int SAMPLE_RATE = 4,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       baud_rate_sample_clk
);

  localparam int DIV_W = (SAMPLE_RATE < 1) ? 1 : $clog2(SAMPLE_RATE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_RATE);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [3:0]       TICK_LAST = 4'(OVERSAMPLE - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4
  } state_t;
`endif

  state_t           state_r, state_s;
  logic [DIV_W-1:0] div_r, div_s;
  logic             bclk_r, bclk_s;
  logic [3:0]       tick_r, tick_cnt_s;
  logic [2:0]       bit_r, bit_s;
  logic [7:0]       shift_r, shift_s;
  logic             tx_r, tx_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             tick_s;
  logic             bit_end_s;
`ifdef UART_TX_PARITY_EN
  logic             par_r, par_s;
`endif

  // Next-state, counters and next registered outputs
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    bit_s      = bit_r;
    tick_cnt_s = tick_r;
    done_s     = 1'b0;
    tx_s       = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_s      = par_r;
`endif
    // Sample tick fires once per full sample-clock period (falling toggle)
    tick_s    = (div_r == DIV_LAST) && bclk_r;
    bit_end_s = tick_s && (tick_r == TICK_LAST);
    if (div_r == DIV_LAST) begin
      div_s  = '0;
      bclk_s = ~bclk_r;
    end else begin
      div_s  = div_r + DIV_ONE;
      bclk_s = bclk_r;
    end
    if ((state_r != IDLE) && tick_s) begin
      if (tick_r == TICK_LAST) begin
        tick_cnt_s = 4'd0;
      end else begin
        tick_cnt_s = tick_r + 4'd1;
      end
    end else begin
      tick_cnt_s = tick_r;
    end

    case (state_r)
      IDLE: begin
        if (tx_start) begin
          state_s    = START;
          shift_s    = tx_data;
          div_s      = '0;
          bclk_s     = 1'b0;
          tick_cnt_s = 4'd0;
          bit_s      = 3'd0;
`ifdef UART_TX_PARITY_EN
          par_s      = even_parity(tx_data);
`endif
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_s = {1'b0, shift_r[7:1]};
          bit_s   = bit_r + 3'd1;
          if (bit_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Line level is derived from the state being entered so tx is registered
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_s = par_s;
`endif
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      div_r   <= '0;
      bclk_r  <= 1'b0;
      tick_r  <= 4'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      div_r   <= div_s;
      bclk_r  <= bclk_s;
      tick_r  <= tick_cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
`ifdef UART_TX_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

  assign tx                   = tx_r;
  assign tx_busy              = busy_r;
  assign tx_done              = done_r;
  assign baud_rate_sample_clk = bclk_r;

endmodule

// File: tb/tb_mod_uart_tx.sv
// Self-checking bench for mod_uart_tx: frame-level reference model compared every
// cycle, plus directed literal checks (works with or without UART_TX_PARITY_EN).
module tb_mod_uart_tx;
  localparam int SR       = 4;
  localparam int OS       = 16;
  localparam int BIT_CLKS = 2 * (SR + 1) * OS;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS     = 11;
  localparam int EXP_FRAME = 1760;
  localparam logic [10:0] SLOTS_A5 = 11'h54A;
`else
  localparam int NBITS     = 10;
  localparam int EXP_FRAME = 1600;
  localparam logic [10:0] SLOTS_A5 = 11'h34A;
`endif
  localparam int FRAME = NBITS * BIT_CLKS;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx, tx_busy, tx_done, bclk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  bit cmp_on = 1'b0;

  mod_uart_tx #(.SAMPLE_RATE(SR), .OVERSAMPLE(OS)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done), .baud_rate_sample_clk(bclk)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a bit list indexed by cycles since acceptance
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  int          m_k      = 0;
  int          m_ph     = 0;
  logic [10:0] m_bits   = 11'h7FF;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_k      <= 0;
      m_ph     <= 0;
    end else if (!m_active && tx_start) begin
      m_active <= 1'b1;
      m_done   <= 1'b0;
      m_k      <= 0;
      m_ph     <= 0;
`ifdef UART_TX_PARITY_EN
      m_bits   <= {1'b1, ^tx_data, tx_data, 1'b0};
`else
      m_bits   <= {2'b11, tx_data, 1'b0};
`endif
    end else begin
      m_ph   <= m_ph + 1;
      m_done <= m_active && (m_k + 1 == FRAME);
      if (m_active) begin
        m_k <= m_k + 1;
        if (m_k + 1 == FRAME) m_active <= 1'b0;
      end
    end
  end

  function automatic logic exp_tx();
    if (m_active) return m_bits[m_k / BIT_CLKS];
    return 1'b1;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      check("tx_line", {31'd0, tx}, {31'd0, exp_tx()});
      check("tx_busy", {31'd0, tx_busy}, {31'd0, m_active});
      check("tx_done", {31'd0, tx_done}, {31'd0, m_done});
      check("sample_clk", {31'd0, bclk}, 32'((m_ph / (SR + 1)) % 2));
      if (tx_done) done_seen++;
    end
  end

  // Sends one byte (called at a negedge); samples each bit slot mid-bit
  task automatic send(input logic [7:0] d, input int poke,
                      output logic [10:0] slots, output int busy_n, output int done_at);
    tx_start = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    slots = 11'd0; busy_n = 0; done_at = 0;
    for (int c = 1; c <= FRAME + 4; c++) begin
      if (tx_busy) busy_n++;
      if (tx_done && done_at == 0) done_at = c;
      if ((c - 1) % BIT_CLKS == BIT_CLKS / 2) slots[(c - 1) / BIT_CLKS] = tx;
      if (c == poke) begin
        tx_start = 1'b1;
        tx_data  = 8'hFF;
      end else begin
        tx_start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int limit, output int cnt);
    cnt = 0;
    while (!tx_done && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic send_check(input string name, input logic [7:0] d);
    logic [10:0] s;
    int b, da;
    send(d, 0, s, b, da);
    check({name, "_byte"}, {24'd0, s[8:1]}, {24'd0, d});
    check({name, "_framing"}, {30'd0, s[0], s[NBITS-1]}, 32'd1);
    check({name, "_done_at"}, da, FRAME + 1);
  endtask

  initial begin
    logic [10:0] slots;
    int busy_n, done_at, cnt, snap;
    logic [7:0] rb;

    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, tx_busy}, 32'd0);
    check("reset_done", {31'd0, tx_done}, 32'd0);
    check("reset_sclk", {31'd0, bclk}, 32'd0);
    cmp_on = 1'b1;
    reset  = 1'b1;

    // Single frame 0xA5 with hand-computed slot pattern
    send(8'hA5, 0, slots, busy_n, done_at);
    check("a5_slots", {21'd0, slots}, {21'd0, SLOTS_A5});
    check("a5_busy_len", busy_n, EXP_FRAME);
    check("a5_done_at", done_at, EXP_FRAME + 1);

`ifdef UART_TX_PARITY_EN
    send(8'h07, 0, slots, busy_n, done_at);
    check("par07_bit", {31'd0, slots[9]}, 32'd1);
    check("par07_len", busy_n, 1760);
    send(8'h03, 0, slots, busy_n, done_at);
    check("par03_bit", {31'd0, slots[9]}, 32'd0);
`endif

    // Busy rejection: a 0xFF request mid-frame must be ignored
    snap = done_seen;
    send(8'h12, 500, slots, busy_n, done_at);
    check("busy_rej_byte", {24'd0, slots[8:1]}, 32'h12);
    check("busy_rej_dones", done_seen - snap, 1);

    // Back-to-back with tx_start held high
    tx_start = 1'b1;
    tx_data  = 8'h55;
    @(negedge clk);
    wait_done(FRAME + 10, cnt);
    check("b2b_first_len", cnt, FRAME);
    tx_data = 8'h00;
    check("b2b_done_line", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("b2b_start_line", {31'd0, tx}, 32'd0);
    check("b2b_start_busy", {31'd0, tx_busy}, 32'd1);
    wait_done(FRAME + 10, cnt);
    check("b2b_second_len", cnt, FRAME);
    tx_start = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_stops", {31'd0, tx_busy}, 32'd0);

    // Reset during data bit 3 (bit 3 forced low so the async rise is visible)
    snap = done_seen;
    tx_start = 1'b1;
    tx_data  = 8'($urandom) & 8'hF7;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (4 * BIT_CLKS + 40) @(negedge clk);
    check("pre_reset_bit3", {31'd0, tx}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("async_reset_tx", {31'd0, tx}, 32'd1);
    check("async_reset_busy", {31'd0, tx_busy}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    send_check("after_reset", 8'h3C);
    check("reset_no_done", done_seen - snap, 1);

    // Loopback-style decode of corner bytes, then random bytes with random gaps
    send_check("lb00", 8'h00);
    send_check("lbFF", 8'hFF);
    send_check("lb5A", 8'h5A);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      rb = 8'($urandom);
      send_check("rand", rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
